ex_stage_md: RTL and testbench

Parametrised execute stage for the pipelined MIPS CPU: ID/EX pipeline register, three-way operand forwarding, single-cycle ALU and branch-target adder. It also contains an iterative multiply/divide unit (MDU) with HI/LO registers. It replaces the fixed 32-bit EX stage, and adds stall/flush control, operand capture during stalls, and MULT/DIV/MFHI/MFLO/MTHI/MTLO support.

---
 rtl/ex_stage_md_if.sv | 63 ++++++
 rtl/ex_stage_md.sv | 262 ++++++++++++++++++++++++++
 tb/tb_ex_stage_md.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_stage_md_if.sv
// ex_stage_md_if: signal bundle between decode/forwarding sources and the
// execute stage of the pipelined MIPS core.
//
// Handshake: ID offers an instruction by driving id_valid with its fields.
// The instruction is taken into EX on a rising edge where ex_stall is low.
// ex_stall therefore acts as an inverted ready. flush overrides both and
// loads a bubble. EX offers its result to MEM with ex_valid.
// MEM has no back-pressure.
interface ex_stage_md_if #(parameter int XLEN = 32);
    logic            flush;
    logic            id_valid;
    logic [XLEN-1:0] id_inA;
    logic [XLEN-1:0] id_inB;
    logic [XLEN-1:0] id_imm;
    logic [XLEN-1:0] id_pc4;
    logic [3:0]      id_aluc;
    logic            id_aluimm;
    logic            id_shift;
    logic            id_wreg;
    logic            id_m2reg;
    logic            id_wmem;
    logic            id_branch;
    logic            id_regrt;
    logic [4:0]      id_rt;
    logic [4:0]      id_rd;
    logic [3:0]      id_mdop;
    logic [1:0]      id_FWA;
    logic [1:0]      id_FWB;
    logic [XLEN-1:0] mem_aluR;
    logic [XLEN-1:0] wb_dest;

    logic            ex_valid;
    logic            ex_wreg;
    logic            ex_m2reg;
    logic            ex_wmem;
    logic            ex_branch;
    logic            ex_zero;
    logic [XLEN-1:0] ex_aluR;
    logic [XLEN-1:0] ex_inB;
    logic [XLEN-1:0] ex_pc;
    logic [4:0]      ex_destR;
    logic            ex_stall;
    logic            md_busy;
    logic [1:0]      md_state;   // debug view of the MDU state machine

    modport master (
        output flush, id_valid, id_inA, id_inB, id_imm, id_pc4, id_aluc,
               id_aluimm, id_shift, id_wreg, id_m2reg, id_wmem, id_branch,
               id_regrt, id_rt, id_rd, id_mdop, id_FWA, id_FWB, mem_aluR,
               wb_dest,
        input  ex_valid, ex_wreg, ex_m2reg, ex_wmem, ex_branch, ex_zero,
               ex_aluR, ex_inB, ex_pc, ex_destR, ex_stall, md_busy, md_state
    );

    modport slave (
        input  flush, id_valid, id_inA, id_inB, id_imm, id_pc4, id_aluc,
               id_aluimm, id_shift, id_wreg, id_m2reg, id_wmem, id_branch,
               id_regrt, id_rt, id_rd, id_mdop, id_FWA, id_FWB, mem_aluR,
               wb_dest,
        output ex_valid, ex_wreg, ex_m2reg, ex_wmem, ex_branch, ex_zero,
               ex_aluR, ex_inB, ex_pc, ex_destR, ex_stall, md_busy, md_state
    );
endinterface

// File: rtl/ex_stage_md.sv
// ex_stage_md: MIPS execute stage. It contains the ID/EX register, operand
// forwarding, the ALU and the branch-target adder. It also contains an
// iterative multiply/divide unit that holds the HI/LO registers.
module ex_stage_md #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input logic          clk,
    input logic          rst,
    ex_stage_md_if.slave bus
);
    localparam int CW = $clog2(XLEN + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic [1:0] {MD_IDLE = 2'd0, MD_MUL = 2'd1, MD_DIV = 2'd2} md_state_t;
    md_state_t state_q, state_d;

    // ID/EX pipeline register contents
    logic            r_valid, r_aluimm, r_shift, r_wreg, r_m2reg, r_wmem, r_branch, r_regrt;
    logic [3:0]      r_aluc, r_mdop;
    logic [4:0]      r_rt, r_rd;
    logic [1:0]      r_fwa, r_fwb;
    logic [XLEN-1:0] r_a, r_b, r_imm, r_pc4;

    // MDU working registers (shared between multiply and divide)
    logic [XLEN-1:0] acc, shreg, opnd, hi, lo;
    logic            neg_q, neg_r, div_zero;
    logic [CW-1:0]   cnt;

    logic [XLEN-1:0] a_fwd, b_fwd, a_in, b_in, alu_out, alu_r;
    logic [SHW-1:0]  sh;
    logic            md_busy, ex_stall, md_op, md_signed;
    logic            start_mul, start_div, md_done, mt_go;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN:0]   mul_sum, div_sh;
    logic [XLEN-1:0] mul_hi_n, mul_lo_n, div_rem_n, div_q_n;
    logic            div_ge;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0] hi_fin, lo_fin;

    assign md_busy  = (state_q != MD_IDLE);
    assign md_op    = (r_mdop != 4'd0) && (r_mdop <= OP_MTLO);
    assign ex_stall = r_valid & md_busy & md_op;
    assign mt_go    = r_valid & ~ex_stall;

    // Forwarding muxes and ALU operand selection
    always_comb begin
        a_fwd = r_a;
        b_fwd = r_b;
        case (r_fwa)
            2'b00:   a_fwd = r_a;
            2'b01:   a_fwd = bus.mem_aluR;
            default: a_fwd = bus.wb_dest;
        endcase
        case (r_fwb)
            2'b00:   b_fwd = r_b;
            2'b01:   b_fwd = bus.mem_aluR;
            default: b_fwd = bus.wb_dest;
        endcase
        a_in = r_shift  ? {{(XLEN-5){1'b0}}, r_imm[10:6]} : a_fwd;
        b_in = r_aluimm ? r_imm : b_fwd;
        sh   = a_in[SHW-1:0];
    end

    // Single-cycle ALU
    always_comb begin
        alu_out = '0;
        case (r_aluc)
            4'd0:    alu_out = a_in + b_in;
            4'd1:    alu_out = a_in - b_in;
            4'd2:    alu_out = a_in & b_in;
            4'd3:    alu_out = a_in | b_in;
            4'd4:    alu_out = a_in ^ b_in;
            4'd5:    alu_out = ~(a_in | b_in);
            4'd6:    alu_out = {{(XLEN-1){1'b0}}, ($signed(a_in) < $signed(b_in))};
            4'd7:    alu_out = {{(XLEN-1){1'b0}}, (a_in < b_in)};
            4'd8:    alu_out = b_in << sh;
            4'd9:    alu_out = b_in >> sh;
            4'd10:   alu_out = $signed(b_in) >>> sh;
            4'd11:   alu_out = b_in << 16;
            default: alu_out = '0;
        endcase
        alu_r = alu_out;
        if (r_mdop == OP_MFHI) alu_r = hi;
        else if (r_mdop == OP_MFLO) alu_r = lo;
    end

    // Operand magnitudes/signs at MDU entry, plus one shift-add / restoring step
    always_comb begin
        md_signed = (r_mdop == OP_MULT) || (r_mdop == OP_DIV);
        a_neg     = md_signed & a_fwd[XLEN-1];
        b_neg     = md_signed & b_fwd[XLEN-1];
        a_mag     = a_neg ? -a_fwd : a_fwd;
        b_mag     = b_neg ? -b_fwd : b_fwd;

        mul_sum   = {1'b0, acc} + (shreg[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
        {mul_hi_n, mul_lo_n} = {mul_sum, shreg[XLEN-1:1]};

        div_sh    = {acc, shreg[XLEN-1]};
        div_ge    = (div_sh >= {1'b0, opnd});
        div_rem_n = div_ge ? (div_sh[XLEN-1:0] - opnd) : div_sh[XLEN-1:0];
        div_q_n   = {shreg[XLEN-2:0], div_ge};

        // Final-step results with signs restored; a zero divisor leaves the
        // dividend in the remainder, and the quotient is forced to all ones.
        prod_s    = neg_q ? -{mul_hi_n, mul_lo_n} : {mul_hi_n, mul_lo_n};
        if (state_q == MD_MUL) begin
            hi_fin = prod_s[2*XLEN-1:XLEN];
            lo_fin = prod_s[XLEN-1:0];
        end else begin
            hi_fin = neg_r ? -div_rem_n : div_rem_n;
            lo_fin = div_zero ? {XLEN{1'b1}} : (neg_q ? -div_q_n : div_q_n);
        end
    end

    // MDU next-state logic
    always_comb begin
        state_d   = state_q;
        start_mul = 1'b0;
        start_div = 1'b0;
        md_done   = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (r_valid && (r_mdop == OP_MULT || r_mdop == OP_MULTU)) begin
                    start_mul = 1'b1;
                    state_d   = MD_MUL;
                end else if (r_valid && (r_mdop == OP_DIV || r_mdop == OP_DIVU)) begin
                    start_div = 1'b1;
                    state_d   = MD_DIV;
                end
            end
            MD_MUL, MD_DIV: begin
                if (cnt == CW'(1)) begin
                    md_done = 1'b1;
                    state_d = MD_IDLE;
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    // MDU state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= MD_IDLE;
        else     state_q <= state_d;
    end

    // MDU datapath and HI/LO
    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            shreg    <= '0;
            opnd     <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            if (start_mul || start_div) begin
                acc      <= '0;
                shreg    <= start_mul ? b_mag : a_mag;
                opnd     <= start_mul ? a_mag : b_mag;
                neg_q    <= a_neg ^ b_neg;
                neg_r    <= a_neg;
                div_zero <= (b_fwd == '0);
                cnt      <= CW'(XLEN);
            end else if (state_q == MD_MUL) begin
                acc   <= mul_hi_n;
                shreg <= mul_lo_n;
                cnt   <= cnt - CW'(1);
            end else if (state_q == MD_DIV) begin
                acc   <= div_rem_n;
                shreg <= div_q_n;
                cnt   <= cnt - CW'(1);
            end
            if (md_done) begin
                hi <= hi_fin;
                lo <= lo_fin;
            end else if (mt_go && r_mdop == OP_MTHI) begin
                hi <= a_fwd;
            end else if (mt_go && r_mdop == OP_MTLO) begin
                lo <= a_fwd;
            end
        end
    end

    // ID/EX register: bubble on rst/flush, operand capture while stalled
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            r_valid  <= 1'b0;
            r_aluimm <= 1'b0;
            r_shift  <= 1'b0;
            r_wreg   <= 1'b0;
            r_m2reg  <= 1'b0;
            r_wmem   <= 1'b0;
            r_branch <= 1'b0;
            r_regrt  <= 1'b0;
            r_aluc   <= '0;
            r_mdop   <= '0;
            r_rt     <= '0;
            r_rd     <= '0;
            r_fwa    <= '0;
            r_fwb    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_imm    <= '0;
            r_pc4    <= '0;
        end else if (ex_stall) begin
            // MEM/WB keep draining during the stall, so freeze the forwarded values now
            r_a   <= a_fwd;
            r_b   <= b_fwd;
            r_fwa <= 2'b00;
            r_fwb <= 2'b00;
        end else begin
            r_valid  <= bus.id_valid;
            r_aluimm <= bus.id_aluimm;
            r_shift  <= bus.id_shift;
            r_wreg   <= bus.id_wreg;
            r_m2reg  <= bus.id_m2reg;
            r_wmem   <= bus.id_wmem;
            r_branch <= bus.id_branch;
            r_regrt  <= bus.id_regrt;
            r_aluc   <= bus.id_aluc;
            r_mdop   <= bus.id_mdop;
            r_rt     <= bus.id_rt;
            r_rd     <= bus.id_rd;
            r_fwa    <= bus.id_FWA;
            r_fwb    <= bus.id_FWB;
            r_a      <= bus.id_inA;
            r_b      <= bus.id_inB;
            r_imm    <= bus.id_imm;
            r_pc4    <= bus.id_pc4;
        end
    end

    // Outputs. A stalled instruction looks like a bubble to MEM.
    // ex_zero is qualified by valid so that a reset/bubble stage drives all zeros.
    assign bus.ex_valid  = r_valid & ~ex_stall;
    assign bus.ex_wreg   = r_wreg & ~ex_stall;
    assign bus.ex_wmem   = r_wmem & ~ex_stall;
    assign bus.ex_branch = r_branch & ~ex_stall;
    assign bus.ex_m2reg  = r_m2reg;
    assign bus.ex_aluR   = alu_r;
    assign bus.ex_zero   = r_valid & (alu_r == '0);
    assign bus.ex_inB    = b_fwd;
    assign bus.ex_pc     = r_pc4 + (r_imm << 2);
    assign bus.ex_destR  = r_regrt ? r_rt : r_rd;
    assign bus.ex_stall  = ex_stall;
    assign bus.md_busy   = md_busy;
    assign bus.md_state  = state_q;
endmodule

// File: tb/tb_ex_stage_md.sv
// tb_ex_stage_md: directed self-checking bench for the execute stage.
module tb_ex_stage_md;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] ONES = '1;
    localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic [XLEN-1:0] exp_q[$];

    ex_stage_md_if #(.XLEN(XLEN)) bus ();

    ex_stage_md #(.XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_id();
        bus.flush     = 1'b0;
        bus.id_valid  = 1'b0;
        bus.id_inA    = '0;
        bus.id_inB    = '0;
        bus.id_imm    = '0;
        bus.id_pc4    = '0;
        bus.id_aluc   = '0;
        bus.id_aluimm = 1'b0;
        bus.id_shift  = 1'b0;
        bus.id_wreg   = 1'b0;
        bus.id_m2reg  = 1'b0;
        bus.id_wmem   = 1'b0;
        bus.id_branch = 1'b0;
        bus.id_regrt  = 1'b0;
        bus.id_rt     = '0;
        bus.id_rd     = '0;
        bus.id_mdop   = '0;
        bus.id_FWA    = '0;
        bus.id_FWB    = '0;
    endtask

    task automatic issue_md(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        clear_id();
        bus.id_valid = 1'b1;
        bus.id_mdop  = op;
        bus.id_inA   = a;
        bus.id_inB   = b;
        bus.id_wreg  = (op == OP_MFHI || op == OP_MFLO);
        bus.id_rd    = 5'd9;
    endtask

    // Counts stalled cycles; flags any stalled cycle that leaks a write or shows MDU idle
    task automatic wait_stall(output int n, output bit leak);
        n = 0;
        leak = 1'b0;
        while (bus.ex_stall && n < 200) begin
            if (bus.ex_wreg || bus.ex_valid || !bus.md_busy) leak = 1'b1;
            n++;
            tick();
        end
    endtask

    // Driver for one ALU instruction; checks result and zero flag in EX
    task automatic alu_vec(input string tag, input logic [3:0] aluc,
                           input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                           input logic [XLEN-1:0] imm, input logic [1:0] fwa,
                           input logic [1:0] fwb, input logic aluimm, input logic shift,
                           input logic [XLEN-1:0] mem, input logic [XLEN-1:0] wb,
                           input logic [XLEN-1:0] exp_r, input logic exp_z);
        clear_id();
        bus.id_valid  = 1'b1;
        bus.id_wreg   = 1'b1;
        bus.id_aluc   = aluc;
        bus.id_inA    = a;
        bus.id_inB    = b;
        bus.id_imm    = imm;
        bus.id_pc4    = 'h100;
        bus.id_rd     = 5'd3;
        bus.id_rt     = 5'd7;
        bus.id_FWA    = fwa;
        bus.id_FWB    = fwb;
        bus.id_aluimm = aluimm;
        bus.id_shift  = shift;
        tick();
        clear_id();
        bus.mem_aluR = mem;
        bus.wb_dest  = wb;
        #1;
        check({tag, "_aluR"}, bus.ex_aluR, exp_r);
        check({tag, "_zero"}, bus.ex_zero, exp_z);
    endtask

    // Runs a MULT/DIV, then reads both HI and LO back through MFHI/MFLO
    task automatic md_run(input string tag, input logic [3:0] op,
                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic [XLEN-1:0] exp_hi, input logic [XLEN-1:0] exp_lo,
                          input bit hi_first);
        int n;
        bit leak;
        issue_md(op, a, b);
        tick();
        check({tag, "_busy_at_issue"}, bus.md_busy, 1'b0);
        issue_md(hi_first ? OP_MFHI : OP_MFLO, '0, '0);
        tick();
        clear_id();
        wait_stall(n, leak);
        check({tag, "_stall_cycles"}, n, XLEN);
        check({tag, "_stall_bubble"}, leak, 1'b0);
        exp_q.push_back(hi_first ? exp_hi : exp_lo);
        exp_q.push_back(hi_first ? exp_lo : exp_hi);
        check({tag, "_first_read"}, bus.ex_aluR, exp_q.pop_front());
        check({tag, "_first_wreg"}, bus.ex_wreg, 1'b1);
        issue_md(hi_first ? OP_MFLO : OP_MFHI, '0, '0);
        tick();
        clear_id();
        check({tag, "_second_read"}, bus.ex_aluR, exp_q.pop_front());
    endtask

    // Main directed sequence
    initial begin
        int n;
        bit leak;
        logic [XLEN-1:0] cap;
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        clear_id();
        bus.mem_aluR = '0;
        bus.wb_dest  = '0;
        tick();
        tick();
        check("rst_valid", bus.ex_valid, 1'b0);
        check("rst_aluR", bus.ex_aluR, '0);
        check("rst_zero", bus.ex_zero, 1'b0);
        check("rst_pc", bus.ex_pc, '0);
        check("rst_destR", bus.ex_destR, '0);
        check("rst_stall", bus.ex_stall, 1'b0);
        check("rst_busy", bus.md_busy, 1'b0);
        check("rst_inB", bus.ex_inB, '0);
        rst = 1'b0;

        // ALU vectors
        alu_vec("add_fwa", 4'd0, 'd100, 'd7, 'd4, 2'b01, 2'b00, 1'b0, 1'b0, 'd5, '0, 'd12, 1'b0);
        check("add_pc", bus.ex_pc, 'h110);
        check("add_destR", bus.ex_destR, 5'd3);
        check("add_inB", bus.ex_inB, 'd7);
        check("add_valid", bus.ex_valid, 1'b1);
        alu_vec("sub_zero", 4'd1, 'd9, 'd9, '0, 2'b00, 2'b00, 1'b0, 1'b0, '0, '0, '0, 1'b1);
        alu_vec("slt_fwb_wb", 4'd6, ONES, 'd50, '0, 2'b00, 2'b10, 1'b0, 1'b0, '0, 'd1, 'd1, 1'b0);
        alu_vec("sltu", 4'd7, ONES, 'd1, '0, 2'b00, 2'b00, 1'b0, 1'b0, '0, '0, '0, 1'b1);
        alu_vec("sra_imm", 4'd10, '0, MINV, 'h100, 2'b00, 2'b00, 1'b0, 1'b1, '0, '0, ~(ONES >> 5), 1'b0);
        alu_vec("srl_imm", 4'd9, '0, MINV, 'h100, 2'b00, 2'b00, 1'b0, 1'b1, '0, '0, MINV >> 4, 1'b0);
        alu_vec("sll_reg", 4'd8, 'd3, 'd1, '0, 2'b00, 2'b00, 1'b0, 1'b0, '0, '0, 'd8, 1'b0);
        alu_vec("lui", 4'd11, '0, '0, 'h1234, 2'b00, 2'b00, 1'b1, 1'b0, '0, '0, XLEN'(64'h1234 << 16), 1'b0);
        alu_vec("nor", 4'd5, '0, '0, '0, 2'b00, 2'b00, 1'b0, 1'b0, '0, '0, ONES, 1'b0);
        alu_vec("and", 4'd2, 'hF0F0, 'hFF00, '0, 2'b00, 2'b00, 1'b0, 1'b0, '0, '0, 'hF000, 1'b0);
        alu_vec("xor", 4'd4, 'hF0F0, 'hFF00, '0, 2'b00, 2'b00, 1'b0, 1'b0, '0, '0, 'h0FF0, 1'b0);
        alu_vec("or_imm", 4'd3, 'h0F, '0, 'hF0, 2'b00, 2'b00, 1'b1, 1'b0, '0, '0, 'hFF, 1'b0);
        alu_vec("aluc13", 4'd13, 'd5, 'd6, '0, 2'b00, 2'b00, 1'b0, 1'b0, '0, '0, '0, 1'b1);

        // regrt destination and negative branch offset
        clear_id();
        bus.id_valid = 1'b1;
        bus.id_regrt = 1'b1;
        bus.id_rt    = 5'd7;
        bus.id_rd    = 5'd3;
        bus.id_pc4   = 'h200;
        bus.id_imm   = ONES;
        bus.id_branch = 1'b1;
        tick();
        clear_id();
        check("regrt_destR", bus.ex_destR, 5'd7);
        check("branch_pc_neg", bus.ex_pc, 'h1FC);
        check("branch_flag", bus.ex_branch, 1'b1);

        // Multiply/divide
        md_run("mult", OP_MULT, XLEN'(-3), 'd7, ONES, XLEN'(-21), 1'b1);
        md_run("multu", OP_MULTU, ONES, 'd2, 'd1, ONES << 1, 1'b0);
        md_run("div", OP_DIV, XLEN'(-7), 'd2, XLEN'(-1), XLEN'(-3), 1'b0);
        md_run("divu_zero", OP_DIVU, 'd7, '0, 'd7, ONES, 1'b0);
        md_run("div_zero_neg", OP_DIV, XLEN'(-5), '0, XLEN'(-5), ONES, 1'b0);
        md_run("div_min", OP_DIV, MINV, ONES, '0, MINV, 1'b0);

        // Operand capture: stalled MTLO forwarding from MEM while mem_aluR keeps changing
        issue_md(OP_MULT, 'd3, 'd5);
        tick();
        issue_md(OP_MTLO, 'h55, '0);
        bus.id_FWA = 2'b01;
        tick();
        clear_id();
        cap = XLEN'($urandom_range(1, 1000));
        bus.mem_aluR = cap;
        n = 0;
        leak = 1'b0;
        while (bus.ex_stall && n < 200) begin
            if (bus.ex_wreg || bus.ex_valid) leak = 1'b1;
            n++;
            tick();
            bus.mem_aluR = XLEN'($urandom_range(2000, 3000));
        end
        check("mtlo_stall_cycles", n, XLEN);
        check("mtlo_stall_bubble", leak, 1'b0);
        issue_md(OP_MFLO, '0, '0);
        tick();
        clear_id();
        check("mtlo_captured", bus.ex_aluR, cap);
        issue_md(OP_MFHI, '0, '0);
        tick();
        clear_id();
        check("mtlo_hi_kept", bus.ex_aluR, '0);

        // Non-MDU instruction proceeds during MULT; flush wins over a stall
        issue_md(OP_MULT, 'd6, 'd7);
        tick();
        clear_id();
        bus.id_valid = 1'b1;
        bus.id_wreg  = 1'b1;
        bus.id_inA   = 'd1;
        bus.id_inB   = 'd2;
        tick();
        check("add_during_mul_stall", bus.ex_stall, 1'b0);
        check("add_during_mul_valid", bus.ex_valid, 1'b1);
        check("add_during_mul_aluR", bus.ex_aluR, 'd3);
        check("add_during_mul_busy", bus.md_busy, 1'b1);
        issue_md(OP_MFHI, '0, '0);
        tick();
        clear_id();
        check("mfhi_stalled", bus.ex_stall, 1'b1);
        tick();
        tick();
        bus.flush    = 1'b1;
        bus.id_valid = 1'b1;
        bus.id_wreg  = 1'b1;
        tick();
        clear_id();
        check("flush_stall", bus.ex_stall, 1'b0);
        check("flush_valid", bus.ex_valid, 1'b0);
        check("flush_busy", bus.md_busy, 1'b1);
        n = 0;
        while (bus.md_busy && n < 200) begin
            n++;
            tick();
        end
        check("flush_mdu_done", bus.md_busy, 1'b0);
        issue_md(OP_MFLO, '0, '0);
        tick();
        clear_id();
        check("flush_lo", bus.ex_aluR, 'd42);
        issue_md(OP_MFHI, '0, '0);
        tick();
        clear_id();
        check("flush_hi", bus.ex_aluR, '0);

        // Reset in the middle of a divide
        issue_md(OP_DIV, 'd100, 'd7);
        tick();
        clear_id();
        for (int i = 0; i < 5; i++) tick();
        check("div_busy_before_rst", bus.md_busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_busy", bus.md_busy, 1'b0);
        check("rst_mid_valid", bus.ex_valid, 1'b0);
        check("rst_mid_aluR", bus.ex_aluR, '0);
        check("rst_mid_stall", bus.ex_stall, 1'b0);
        issue_md(OP_MFLO, '0, '0);
        tick();
        clear_id();
        check("rst_mid_lo", bus.ex_aluR, '0);
        check("rst_mid_mflo_stall", bus.ex_stall, 1'b0);
        issue_md(OP_MFHI, '0, '0);
        tick();
        clear_id();
        check("rst_mid_hi", bus.ex_aluR, '0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
